// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the hart memory path: arbiter FSM states and the request
// bundle muxed onto the single memory port.
package riscv_mem_arbiter_pkg;

    localparam int MEM_XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_XLEN-1:0]   addr;
        logic [MEM_XLEN-1:0]   wdata;
        logic [MEM_XLEN/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter_pick.sv
// Fixed-priority pick between fetch (I) and load/store (D): D wins unless the
// starvation guard says I has waited through too many D grants.
module riscv_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve,
    output logic grant_i,
    output logic grant_d
);

    assign grant_d = d_req & ~(i_req & starve);
    assign grant_i = i_req & ~grant_d;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the hart's fetch
// and load/store requesters, with starvation guard and response timeout.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter  int XLEN         = MEM_XLEN,
    parameter  int STARVE_LIMIT = 4,
    parameter  int TIMEOUT      = 15,
    localparam int SW           = $clog2(STARVE_LIMIT + 1),
    localparam int TW           = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_be,
    input  logic              m_rvalid,
    input  logic [XLEN-1:0]   m_rdata,

    output logic              err_timeout,
    output logic [1:0]        dbg_state_o,
    output logic [SW-1:0]     dbg_d_streak_o
);

    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          we_q, we_d;

    logic          arb_en;
    logic          starve;
    logic          grant_i, grant_d;
    logic          resp;
    logic [XLEN-1:0] resp_data;
    mem_req_t      m_sel;

    // Arbitration only happens in IDLE, and the rst_n term keeps every grant
    // (hence every output) low while reset is held.
    assign arb_en = rst_n & (state_q == ARB_IDLE);
    assign starve = (d_streak_q == STREAK_MAX);

    riscv_arb_pick u_pick (
        .i_req   (i_req & arb_en),
        .d_req   (d_req & arb_en),
        .starve  (starve),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d     = state_q;
        d_streak_d  = d_streak_q;
        timer_d     = timer_q;
        we_d        = we_q;
        m_sel       = '0;
        resp        = 1'b0;
        resp_data   = '0;
        err_timeout = 1'b0;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    d_gnt       = 1'b1;
                    m_sel.we    = d_we;
                    m_sel.addr  = d_addr;
                    m_sel.wdata = d_wdata;
                    m_sel.be    = d_be;
                    state_d     = ARB_WAIT_D;
                    timer_d     = '0;
                    we_d        = d_we;
                    if (!i_req)
                        d_streak_d = '0;
                    else if (d_streak_q != STREAK_MAX)
                        d_streak_d = d_streak_q + SW'(1);
                end else if (grant_i) begin
                    i_gnt       = 1'b1;
                    m_sel.addr  = i_addr;
                    m_sel.be    = '1;
                    state_d     = ARB_WAIT_I;
                    timer_d     = '0;
                    we_d        = 1'b0;
                    d_streak_d  = '0;
                end
            end
            ARB_WAIT_I, ARB_WAIT_D: begin
                timer_d = timer_q + TW'(1);
                // A real response in the last timeout cycle still counts as real.
                if (m_rvalid) begin
                    resp      = 1'b1;
                    resp_data = m_rdata;
                    state_d   = ARB_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    resp        = 1'b1;
                    err_timeout = 1'b1;
                    state_d     = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        i_rvalid = resp & (state_q == ARB_WAIT_I);
        d_rvalid = resp & (state_q == ARB_WAIT_D);
        i_rdata  = i_rvalid ? resp_data : '0;
        // Store acks carry no data, so the memory bus is not leaked onto d_rdata.
        d_rdata  = (d_rvalid && !we_q) ? resp_data : '0;
    end

    assign m_req          = grant_i | grant_d;
    assign m_we           = m_sel.we;
    assign m_addr         = m_sel.addr;
    assign m_wdata        = m_sel.wdata;
    assign m_be           = m_sel.be;
    assign dbg_state_o    = state_q;
    assign dbg_d_streak_o = d_streak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            d_streak_q <= '0;
            timer_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            timer_q    <= timer_d;
            we_q       <= we_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: the bench plays both requesters and
// the memory, with hand-computed expectations per cycle.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        err_timeout;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_streak;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    riscv_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_be           (d_be),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .m_req          (m_req),
        .m_we           (m_we),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_be           (m_be),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata),
        .err_timeout    (err_timeout),
        .dbg_state_o    (dbg_state),
        .dbg_d_streak_o (dbg_streak)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // drive just after the edge, sample mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {25'd0, i_gnt, d_gnt, m_req, m_we, i_rvalid, d_rvalid, err_timeout}, 32'd0);
        check({tag, "_bus"}, m_addr | m_wdata | {28'd0, m_be} | i_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_req    = 1'b1;
        i_addr   = 32'h80;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h40;
        d_wdata  = 32'h0;
        d_be     = 4'hF;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234;

        // 1: outputs held at zero in reset, D wins first cycle after release
        #3;
        check_quiet("rst_async");
        tick(); settle();
        check_quiet("rst_held");
        rst_n = 1'b1; m_rvalid = 1'b0;
        settle();
        check("rst_rel_gnt", {30'd0, d_gnt, i_gnt}, 32'b10);
        check("rst_rel_mreq", {31'd0, m_req}, 32'd1);
        check("rst_rel_addr", m_addr, 32'h40);
        tick();
        i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5A5A;
        settle();
        check("rst_rel_resp", {31'd0, d_rvalid}, 32'd1);
        check("rst_rel_rdata", d_rdata, 32'h5A5A);
        check("rst_rel_streak", {29'd0, dbg_streak}, 32'd1);
        tick(); m_rvalid = 1'b0; settle();
        check("rst_rel_idle", {30'd0, dbg_state}, 32'd0);

        // 2: load answered 3 cycles after grant, then a store
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        settle();
        check("ld_gnt", {30'd0, d_gnt, m_req}, 32'b11);
        check("ld_maddr", m_addr, 32'h100);
        tick(); d_req = 1'b0; settle();
        check("ld_wait", {28'd0, m_req, d_rvalid, dbg_state}, 32'b0010);
        tick(); settle();
        tick(); m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; settle();
        check("ld_resp", {30'd0, d_rvalid, err_timeout}, 32'b10);
        check("ld_rdata", d_rdata, 32'hDEADBEEF);
        tick(); m_rvalid = 1'b0; settle();
        check("ld_idle", {29'd0, dbg_state, d_rvalid}, 32'd0);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h12345678; d_be = 4'b0011;
        settle();
        check("st_mctl", {29'd0, d_gnt, m_we, m_req}, 32'b111);
        check("st_mbe", {28'd0, m_be}, 32'b0011);
        check("st_wdata", m_wdata, 32'h12345678);
        tick();
        d_req = 1'b0; d_we = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
        settle();
        check("st_ack", {31'd0, d_rvalid}, 32'd1);
        check("st_rdata", d_rdata, 32'd0);
        tick(); m_rvalid = 1'b0;

        // 3: starvation guard, grant order D,D,D,D,I,D
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
        d_wdata = 32'hFFFF0000; d_be = 4'h0;
        for (int g = 0; g < 6; g++) begin
            logic [0:0] exp_d;
            exp_d = exp_q.pop_front();
            settle();
            check("starve_gnt", {30'd0, d_gnt, i_gnt}, exp_d ? 32'b10 : 32'b01);
            if (!exp_d) begin
                check("starve_i_addr", m_addr, 32'h200);
                check("starve_i_ctl", {m_wdata[27:0], m_be}, 32'h0000000F);
            end
            tick(); m_rvalid = 1'b1; m_rdata = 32'h1000 + g; settle();
            check("starve_resp", {30'd0, d_rvalid, i_rvalid}, exp_d ? 32'b10 : 32'b01);
            tick(); m_rvalid = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;

        // 4: fetch timeout with a D request pending
        i_req = 1'b1; i_addr = 32'h400; m_rdata = 32'hAAAA5555;
        settle();
        check("to_gnt", {31'd0, i_gnt}, 32'd1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            i_req = 1'b0;
            if (k == 10) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h480; end
            settle();
            if (k < 15) begin
                if (k == 1 || k == 14)
                    check("to_wait", {29'd0, i_rvalid, err_timeout, d_gnt}, 32'd0);
            end else begin
                check("to_fire", {29'd0, i_rvalid, err_timeout, d_gnt}, 32'b110);
                check("to_rdata", i_rdata, 32'd0);
            end
        end
        tick(); settle();
        check("to_next", {30'd0, err_timeout, d_gnt}, 32'b01);
        check("to_next_addr", m_addr, 32'h480);
        tick(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h3; settle();
        check("to_next_resp", {31'd0, d_rvalid}, 32'd1);
        tick(); m_rvalid = 1'b0;

        // 5: m_rvalid on the timeout cycle wins; stray m_rvalid in IDLE ignored
        i_req = 1'b1; i_addr = 32'h500;
        settle();
        for (int k = 1; k <= 15; k++) begin
            tick();
            i_req = 1'b0;
            if (k == 15) begin m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; end
        end
        settle();
        check("race_resp", {30'd0, i_rvalid, err_timeout}, 32'b10);
        check("race_rdata", i_rdata, 32'hCAFEF00D);
        tick(); m_rvalid = 1'b1; m_rdata = 32'h9999; settle();
        check_quiet("stray");
        tick(); m_rvalid = 1'b0;

        // 6: reset during WAIT_D drops the transaction
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; i_addr = 32'h604;
        settle();
        check("rw_gnt", {30'd0, d_gnt, i_gnt}, 32'b10);
        tick(); i_req = 1'b0; d_req = 1'b0; settle();
        check("rw_wait", {27'd0, dbg_streak, dbg_state}, {27'd0, 3'd1, 2'd2});
        rst_n = 1'b0; settle();
        check("rw_in_rst", {26'd0, dbg_streak, dbg_state, d_rvalid}, 32'd0);
        tick(); rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h42; settle();
        check("rw_late", {30'd0, d_rvalid, i_rvalid}, 32'd0);
        tick(); m_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h700; settle();
        check("rw_regnt", {30'd0, d_gnt, m_req}, 32'b11);
        check("rw_regnt_addr", m_addr, 32'h700);
        tick(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; settle();
        check("rw_resp", d_rdata, 32'h77);
        tick(); m_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one single-ported memory between the hart's instruction-fetch requester (I) and its load/store requester (D).
- Only one transaction is outstanding at a time.
- D has priority over I. A starvation guard forces an I grant after STARVE_LIMIT consecutive D grants while I is waiting.
- A response timeout guarantees forward progress if memory never answers.
- Sits between riscv_hart's pc/mem_* ports and the memory model.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive D grants tolerated while i_req is high (>=1)
TIMEOUT, 15, cycles in WAIT state without m_rvalid before forced completion (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_gnt
i_addr  in  XLEN  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch response pulse
i_rdata  out  XLEN  fetch data, valid with i_rvalid
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store data
d_be  in  XLEN/8  store byte enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response pulse (load data or store ack)
d_rdata  out  XLEN  load data, valid with d_rvalid; 0 for store acks
m_req  out  1  memory request strobe
m_we  out  1  memory write
m_addr  out  XLEN  memory address
m_wdata  out  XLEN  memory write data
m_be  out  XLEN/8  memory byte enables; all-ones for fetches
m_rvalid  in  1  memory response (read data or write ack), one pulse per request
m_rdata  in  XLEN  memory read data
err_timeout  out  1  one-cycle pulse when a transaction times out

Behaviour:
States: IDLE, WAIT_I, WAIT_D. Registered: state, d_streak, timer. All grant/response outputs are combinational from state and inputs.

Reset:
- rst_n low -> state=IDLE, d_streak=0, timer=0.
- Every output is 0 while rst_n is low, even if a request input is high.
- Reset mid-transaction drops the transaction; no rvalid is ever issued for it.

IDLE:
- Arbitration is evaluated in the same cycle as the request.
- grant_d = d_req & ~(i_req & d_streak==STARVE_LIMIT).
- grant_i = i_req & ~grant_d.
- A granted requester sees x_gnt=1. In the same cycle m_req=1 and m_addr/m_we/m_wdata/m_be are muxed from the winner. For fetches m_we=0, m_wdata=0 and m_be=all-ones.
- On the next edge state moves to WAIT_I or WAIT_D and timer is cleared to 0.
- With no grant, m_req=0 and all m_* outputs are 0.
- m_rvalid arriving in IDLE (stray or post-reset) is ignored.

d_streak update:
- On a D grant with i_req=1: d_streak+1, saturating at STARVE_LIMIT.
- On a D grant with i_req=0: d_streak=0.
- On any I grant: d_streak=0.

WAIT_x:
- No grants; x_gnt=0; m_req=0.
- timer increments each cycle.
- If m_rvalid=1: x_rvalid=1 and x_rdata=m_rdata combinationally (d_rdata is forced to 0 for a store); next state IDLE.
- Else if timer==TIMEOUT-1: x_rvalid=1, x_rdata=0, err_timeout=1; next state IDLE.
- m_rvalid and the timeout in the same cycle: m_rvalid wins and err_timeout stays 0.
- The response cycle never grants a new request. The minimum spacing between grants is 2 cycles (grant, response).

Requester rules:
- Address and data must be held stable while x_req=1 and x_gnt=0.
- x_req may drop without being granted; the arbiter keeps no memory of the request.

Width rules: timer is $clog2(TIMEOUT+1) bits; d_streak is $clog2(STARVE_LIMIT+1) bits.

Decomposition:
- Add to the shared ISA package: enum arb_state_t {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D} and a packed struct mem_req_t {we, addr, wdata, be}, used for the request mux and later for hart ports.
- One small combinational sub-module is natural, riscv_arb_pick: inputs i_req, d_req, starve; outputs grant_i, grant_d.
- The timer and the streak counter stay inline.

Test Plan:
1. Reset with i_req=d_req=1 and rst_n=0 -> all outputs 0. After release, d_gnt=1 on the first cycle, m_addr=d_addr, i_gnt=0.
2. Load: d_req with d_addr=0x100; memory answers 3 cycles after grant with 0xDEADBEEF -> d_rvalid pulse with d_rdata=0xDEADBEEF, err_timeout=0, state IDLE. Store with d_be=4'b0011 -> m_we=1, m_be=4'b0011, then d_rvalid=1 with d_rdata=0 on the ack.
3. Starvation: i_req and d_req held high, memory answering 1 cycle after grant -> grant order D,D,D,D,I,D... The I grant lands on the 5th grant.
4. Timeout: fetch granted and m_rvalid never asserted -> exactly 15 cycles after the grant, i_rvalid=1, i_rdata=0 and a single-cycle err_timeout. The next pending request is granted the following cycle.
5. m_rvalid coinciding with the timeout cycle -> normal response with m_rdata and err_timeout=0. Stray m_rvalid in IDLE -> no rvalid output.
6. rst_n pulsed low while in WAIT_D, then m_rvalid arrives after release -> no d_rvalid, d_streak=0, and the next request is arbitrated normally.
